// File: rtl/ir_line_loader.sv
// ir_line_loader: streams LINES program-ROM words to the IR decoder, each held HOLD_CYCLES cycles.
// Define IR_LOAD_CHECKSUM_EN to append a mod-2^DATA_WIDTH checksum trailer word after the image.
module ir_line_loader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned LINES       = 256,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hold_req,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  line_strobe,
    output logic                  busy,
    output logic                  load_finished
);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(LINES - 1);

`ifdef IR_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StRead, StHold, StCsum, StDone} state_e;
    logic [DATA_WIDTH-1:0] csum_q;
`else
    typedef enum logic [2:0] {StIdle, StRead, StHold, StDone} state_e;
`endif

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] line_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rbuf_q;
    logic                  rbuf_vld_q;
    logic [DATA_WIDTH-1:0] rd_word;

    // A read issued just before a stall is replayed from the buffer on release.
    assign rd_word = rbuf_vld_q ? rbuf_q : mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            line_q        <= '0;
            cnt_q         <= '0;
            rbuf_q        <= '0;
            rbuf_vld_q    <= 1'b0;
            mem_en        <= 1'b0;
            mem_addr      <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            line_strobe   <= 1'b0;
            busy          <= 1'b0;
            load_finished <= 1'b0;
`ifdef IR_LOAD_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else if (hold_req) begin
            if (state_q == StRead && !rbuf_vld_q) begin
                rbuf_q     <= mem_rdata;
                rbuf_vld_q <= 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q       <= StRead;
                        line_q        <= '0;
                        mem_en        <= 1'b1;
                        mem_addr      <= '0;
                        busy          <= 1'b1;
                        load_finished <= 1'b0;
                        rbuf_vld_q    <= 1'b0;
`ifdef IR_LOAD_CHECKSUM_EN
                        csum_q        <= '0;
`endif
                    end
                end
                StRead: begin
                    state_q     <= StHold;
                    mem_en      <= 1'b0;
                    data_out    <= rd_word;
                    data_valid  <= 1'b1;
                    line_strobe <= 1'b0;
                    cnt_q       <= CNT_W'(1);
                    rbuf_vld_q  <= 1'b0;
`ifdef IR_LOAD_CHECKSUM_EN
                    csum_q      <= csum_q + rd_word;
`endif
                end
                StHold: begin
                    if (cnt_q == HOLD_LAST) begin
                        line_strobe <= 1'b0;
                        if (line_q == LAST_LINE) begin
`ifdef IR_LOAD_CHECKSUM_EN
                            state_q  <= StCsum;
                            data_out <= csum_q;
                            cnt_q    <= CNT_W'(1);
`else
                            state_q       <= StDone;
                            data_out      <= '0;
                            data_valid    <= 1'b0;
                            busy          <= 1'b0;
                            load_finished <= 1'b1;
`endif
                        end else begin
                            state_q    <= StRead;
                            line_q     <= line_q + 1'b1;
                            mem_en     <= 1'b1;
                            mem_addr   <= line_q + 1'b1;
                            data_valid <= 1'b0;
                        end
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        line_strobe <= (cnt_q == HOLD_PRE);
                    end
                end
`ifdef IR_LOAD_CHECKSUM_EN
                StCsum: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q       <= StDone;
                        line_strobe   <= 1'b0;
                        data_out      <= '0;
                        data_valid    <= 1'b0;
                        busy          <= 1'b0;
                        load_finished <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        line_strobe <= (cnt_q == HOLD_PRE);
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
